fft_addr_gen: RTL and testbench
===============================

FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 SHALL have parameter STAGE_GAP, default 2, meaning idle cycles inserted between stages for butterfly pipeline drain (range 0..7).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a transform.
REQ-005 SHALL have port fft_size  input  6  one-hot point count N (6'b000010=2 .. 6'b100000=32), sampled on accepted start.
REQ-006 SHALL have port bf_ready  input  1  downstream butterfly accepts current pair.
REQ-007 SHALL have port bf_valid  output  1  addr_a/addr_b/tw_idx/stage valid.
REQ-008 SHALL have port addr_a  output  5  upper butterfly operand address.
REQ-009 SHALL have port addr_b  output  5  lower butterfly operand address.
REQ-010 SHALL have port tw_idx  output  4  twiddle exponent k of W32^k (32-point normalised ROM index).
REQ-011 SHALL have port stage  output  3  current stage s, 0..L-1, L=log2(N).
REQ-012 SHALL have port last_in_stage  output  1  qualifies final butterfly of current stage.
REQ-013 SHALL have ports busy, done, err  output  1 each  transform active / one-cycle completion pulse / invalid size flag.

Function
REQ-014 SHALL implement states IDLE, RUN, GAP, FIN.
REQ-015 SHALL in IDLE accept start; start while not IDLE SHALL be ignored.
REQ-016 SHALL, on accepted start at cycle t, latch N and L, clear s and butterfly index k, enter RUN, and assert bf_valid at t+1 with the first pair.
REQ-017 SHALL compute, with half=2^s, pos=k&(half-1), grp=k>>s: addr_a=grp*2*half+pos; addr_b=addr_a+half; tw_idx=pos<<(4-s), 4-bit truncation.
REQ-018 SHALL hold all output values stable while bf_valid=1 and bf_ready=0.
REQ-019 SHALL advance k only on bf_valid&&bf_ready; k runs 0..N/2-1 per stage.
REQ-020 SHALL assert last_in_stage when k=N/2-1.
REQ-021 SHALL, on acceptance with last_in_stage and s<L-1, increment s, clear k, enter GAP with bf_valid=0 for exactly STAGE_GAP cycles, then RUN; STAGE_GAP=0 SHALL go directly to RUN with no bubble.
REQ-022 SHALL, on acceptance of the last pair with s=L-1, enter FIN: done=1 for exactly one cycle, then IDLE.
REQ-023 SHALL hold busy=1 in RUN, GAP, FIN; busy=0 in IDLE.
REQ-024 SHALL emit exactly (N/2)*L pairs per transform.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE and drive bf_valid=0, addr_a=0, addr_b=0, tw_idx=0, stage=0, last_in_stage=0, busy=0, done=0, err=0.
REQ-026 SHALL let rst mid-transform abort immediately without a done pulse; start in the same cycle as rst SHALL be ignored.

Configuration
REQ-027 SHALL define macro FFT_AGU_SIZE_CHECK_EN.
REQ-028 SHALL, with the macro defined, treat start with fft_size not one-hot or equal to 6'b000001/6'b000000 as invalid: set err=1 (sticky until next valid start or rst) and stay IDLE.
REQ-029 SHALL, without the macro, tie err to 0, use the highest set bit of fft_size as N, and treat 6'b000000/6'b000001 as N=2.

Verification
REQ-030 SHALL cover: N=4, bf_ready=1, STAGE_GAP=2 -> pairs (0,1,0),(2,3,0), two bubbles, (0,2,0),(1,3,8); done on cycle after last pair.
REQ-031 SHALL cover: N=32, bf_ready=1 -> 80 pairs; stage 4 first pair (0,16,0), second (1,17,1); last pair (15,31,15).
REQ-032 SHALL cover: N=8, bf_ready low 3 cycles on second pair -> (2,3,0) held stable 4 cycles, no pair skipped or duplicated.
REQ-033 SHALL cover: rst asserted during stage 1 of N=16 -> next cycle bf_valid=0, busy=0, no done; new start runs full 32 pairs.
REQ-034 SHALL cover: fft_size=6'b010100 with macro -> err=1, busy=0, bf_valid=0; without macro -> 16-point run, 32 pairs.
REQ-035 SHALL cover: start pulsed during RUN of N=8 -> ignored; exactly 12 pairs and one done.

Source files
------------

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: radix-2 FFT butterfly address generator for 2..32 points.
// Walks every stage of an N-point transform and issues one operand pair
// (addr_a, addr_b) plus its twiddle index per accepted handshake. Stages are
// separated by STAGE_GAP idle cycles so the butterfly pipeline can drain.
// Optional build macro FFT_AGU_SIZE_CHECK_EN: reject malformed fft_size with
// a sticky err flag instead of rounding to the highest set bit.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | presenting butterfly pairs of the current stage
// GAP   | bubble cycles between stages (pipeline drain)
// FIN   | one-cycle done pulse after the final pair
module fft_addr_gen #(
  parameter int STAGE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] fft_size,
  input  logic       bf_ready,
  output logic       bf_valid,
  output logic [4:0] addr_a,
  output logic [4:0] addr_b,
  output logic [3:0] tw_idx,
  output logic [2:0] stage,
  output logic       last_in_stage,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

  // Gap counter counts down from STAGE_GAP-1 to 0, giving exactly STAGE_GAP bubbles.
  localparam logic [2:0] GAP_LOAD = (STAGE_GAP > 0) ? 3'(STAGE_GAP - 1) : 3'd0;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] k_q;
  logic [2:0] s_q;
  logic [2:0] l_q;
  logic [2:0] gap_q;

  logic [2:0] size_log2;
  logic       size_ok;
  logic       start_acc;
  logic       pair_acc;
  logic [3:0] k_last;
  logic       last_k;
  logic       last_stage;

  logic [4:0] half;
  logic [4:0] pos;
  logic [4:0] pair_a;
  logic [4:0] pair_b;
  logic [3:0] pair_tw;

  // Decode requested size into log2(N); zero or bit-0-only sizes collapse to N=2.
  always_comb begin
    size_log2 = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (fft_size[i]) size_log2 = 3'(i);
    end
    if (size_log2 == 3'd0) size_log2 = 3'd1;
`ifdef FFT_AGU_SIZE_CHECK_EN
    size_ok = ((fft_size & (fft_size - 6'd1)) == 6'd0) && (fft_size[5:1] != 5'd0);
`else
    size_ok = 1'b1;
`endif
  end

  // Handshake and end-of-stage / end-of-transform qualifiers.
  always_comb begin
    start_acc  = (state_q == IDLE) && start && size_ok;
    pair_acc   = (state_q == RUN) && bf_ready;
    k_last     = 4'((5'd1 << (l_q - 3'd1)) - 5'd1);
    last_k     = (k_q == k_last);
    last_stage = (s_q == (l_q - 3'd1));
  end

  // Pair address math: insert a zero at bit s of k for addr_a, set it for addr_b.
  always_comb begin
    half    = 5'd1 << s_q;
    pos     = {1'b0, k_q} & (half - 5'd1);
    pair_a  = (({1'b0, k_q} >> s_q) << (s_q + 3'd1)) | pos;
    pair_b  = pair_a | half;
    pair_tw = 4'(pos << (3'd4 - s_q));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_acc) state_d = RUN;
      RUN: begin
        if (pair_acc && last_k) begin
          if (last_stage)          state_d = FIN;
          else if (STAGE_GAP == 0) state_d = RUN;
          else                     state_d = GAP;
        end
      end
      GAP:     if (gap_q == 3'd0) state_d = RUN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Butterfly index, stage and bubble counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= 4'd0;
      s_q   <= 3'd0;
      l_q   <= 3'd1;
      gap_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            k_q <= 4'd0;
            s_q <= 3'd0;
            l_q <= size_log2;
          end
        end
        RUN: begin
          if (pair_acc) begin
            if (last_k) begin
              k_q <= 4'd0;
              if (!last_stage) begin
                s_q   <= s_q + 3'd1;
                gap_q <= GAP_LOAD;
              end
            end else begin
              k_q <= k_q + 4'd1;
            end
          end
        end
        GAP: begin
          if (gap_q != 3'd0) gap_q <= gap_q - 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FFT_AGU_SIZE_CHECK_EN
  logic err_q;

  // Sticky size error: set by a rejected start, cleared by a valid start.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      err_q <= !size_ok;
    end
  end
`endif

  // Outputs; pair fields read as zero whenever no pair is being presented.
  always_comb begin
    bf_valid      = (state_q == RUN);
    busy          = (state_q != IDLE);
    done          = (state_q == FIN);
    addr_a        = bf_valid ? pair_a  : 5'd0;
    addr_b        = bf_valid ? pair_b  : 5'd0;
    tw_idx        = bf_valid ? pair_tw : 4'd0;
    stage         = bf_valid ? s_q     : 3'd0;
    last_in_stage = bf_valid && last_k;
`ifdef FFT_AGU_SIZE_CHECK_EN
    err           = err_q;
`else
    err           = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Testbench for fft_addr_gen: scoreboard of expected butterfly pairs built
// from a group/position walk of each stage, checked as the DUT hands them out.
module tb_fft_addr_gen;

  localparam int STAGE_GAP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] fft_size;
  logic       bf_ready;
  logic       bf_valid;
  logic [4:0] addr_a;
  logic [4:0] addr_b;
  logic [3:0] tw_idx;
  logic [2:0] stage;
  logic       last_in_stage;
  logic       busy;
  logic       done;
  logic       err;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [3:0] tw;
    logic [2:0] stg;
    logic       last;
  } pair_t;

  pair_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  fft_addr_gen #(.STAGE_GAP(STAGE_GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .fft_size     (fft_size),
    .bf_ready     (bf_ready),
    .bf_valid     (bf_valid),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .tw_idx       (tw_idx),
    .stage        (stage),
    .last_in_stage(last_in_stage),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected pairs: per stage, walk groups of 2*half points, position p inside a group.
  task automatic push_expected(input int lg);
    int    n;
    int    half;
    pair_t e;
    n = 1 << lg;
    for (int s = 0; s < lg; s++) begin
      half = 1 << s;
      for (int g = 0; g < n / (2 * half); g++) begin
        for (int p = 0; p < half; p++) begin
          e.a    = 5'(g * 2 * half + p);
          e.b    = 5'(g * 2 * half + p + half);
          e.tw   = 4'((p * (16 >> s)) % 16);
          e.stg  = 3'(s);
          e.last = (g == n / (2 * half) - 1) && (p == half - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic run_xfer(input string name, input logic [5:0] size, input int lg,
                          input int stall_idx, input int stall_len, input bit poke_start);
    int    n_pairs;
    int    idx;
    int    stalled;
    int    bubbles;
    bit    want_gap;
    bit    want_done;
    bit    finished;
    pair_t e;
    pair_t got;
    exp_q.delete();
    push_expected(lg);
    n_pairs   = exp_q.size();
    idx       = 0;
    stalled   = 0;
    bubbles   = 0;
    want_gap  = 1'b0;
    want_done = 1'b0;
    finished  = 1'b0;
    fft_size  = size;
    bf_ready  = 1'b1;
    start     = 1'b1;
    tick;
    start = 1'b0;
    vectors++;
    if (bf_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s first_pair_latency: bf_valid=%0b busy=%0b, required 1 1", name, bf_valid, busy);
    end
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      start    = 1'b0;
      bf_ready = 1'b1;
      if (want_done) begin
        vectors++;
        if (done !== 1'b1 || bf_valid !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL %s done_pulse: done=%0b bf_valid=%0b busy=%0b, required 1 0 1", name, done, bf_valid, busy);
        end
        tick;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL %s back_to_idle: done=%0b busy=%0b, required 0 0", name, done, busy);
        end
        finished = 1'b1;
      end else if (done === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL %s early_done: done=1 after %0d of %0d pairs, required 0", name, idx, n_pairs);
        tick;
      end else if (bf_valid === 1'b1) begin
        if (want_gap) begin
          vectors++;
          if (bubbles != STAGE_GAP) begin
            miscompares++;
            $display("FAIL %s stage_gap: %0d bubbles, required %0d", name, bubbles, STAGE_GAP);
          end
          want_gap = 1'b0;
        end
        bubbles = 0;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL %s extra_pair: (%0d,%0d,%0d) beyond %0d pairs", name, addr_a, addr_b, tw_idx, n_pairs);
          tick;
        end else begin
          e   = exp_q[0];
          got = {addr_a, addr_b, tw_idx, stage, last_in_stage};
          vectors++;
          if (got !== e) begin
            miscompares++;
            $display("FAIL %s pair%0d: got a=%0d b=%0d tw=%0d s=%0d last=%0b, required a=%0d b=%0d tw=%0d s=%0d last=%0b",
                     name, idx, got.a, got.b, got.tw, got.stg, got.last, e.a, e.b, e.tw, e.stg, e.last);
          end
          if (poke_start && idx == 3) start = 1'b1;
          if (idx == stall_idx && stalled < stall_len) begin
            bf_ready = 1'b0;
            stalled++;
          end else begin
            void'(exp_q.pop_front());
            idx++;
            if (e.last) begin
              if (int'(e.stg) == lg - 1) want_done = 1'b1;
              else                       want_gap  = 1'b1;
            end
          end
          tick;
        end
      end else begin
        if (busy === 1'b1) bubbles++;
        tick;
      end
    end
    start    = 1'b0;
    bf_ready = 1'b1;
    if (!finished) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: %0d of %0d pairs, no done within budget", name, idx, n_pairs);
    end
    vectors++;
    if (idx != n_pairs || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s pair_count: %0d accepted, required %0d", name, idx, n_pairs);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s err_flag: err=%0b, required 0", name, err);
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    start    = 1'b1;
    fft_size = 6'b000100;
    bf_ready = 1'b1;
    tick;
    tick;
    vectors++;
    if ({bf_valid, addr_a, addr_b, tw_idx, stage, last_in_stage, busy, done, err} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: v=%0b a=%0d b=%0d tw=%0d s=%0d last=%0b busy=%0b done=%0b err=%0b, required all 0",
               bf_valid, addr_a, addr_b, tw_idx, stage, last_in_stage, busy, done, err);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick;
    vectors++;
    if (busy !== 1'b0 || bf_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_start_ignored: busy=%0b bf_valid=%0b, required 0 0", busy, bf_valid);
    end
  endtask

  task automatic test_n4_gap;
    run_xfer("n4_gap", 6'b000100, 2, -1, 0, 1'b0);
  endtask

  task automatic test_n32;
    run_xfer("n32", 6'b100000, 5, -1, 0, 1'b0);
  endtask

  task automatic test_stall;
    run_xfer("n8_stall", 6'b001000, 3, 1, 3, 1'b0);
  endtask

  task automatic test_start_ignored;
    run_xfer("n8_start_in_run", 6'b001000, 3, -1, 0, 1'b1);
  endtask

  task automatic test_reset_mid;
    bit seen;
    seen     = 1'b0;
    fft_size = 6'b010000;
    bf_ready = 1'b1;
    start    = 1'b1;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      if (bf_valid === 1'b1 && stage === 3'd1) seen = 1'b1;
      else tick;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rst_mid_reach_stage1: stage 1 never presented, required within 200 cycles");
    end
    tick;
    rst   = 1'b1;
    start = 1'b1;
    tick;
    rst   = 1'b0;
    start = 1'b0;
    vectors++;
    if (bf_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_abort: bf_valid=%0b busy=%0b done=%0b, required 0 0 0", bf_valid, busy, done);
    end
    tick;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: busy=%0b done=%0b, required 0 0", busy, done);
    end
    run_xfer("n16_after_rst", 6'b010000, 4, -1, 0, 1'b0);
  endtask

  task automatic test_size;
`ifdef FFT_AGU_SIZE_CHECK_EN
    fft_size = 6'b010100;
    start    = 1'b1;
    tick;
    start = 1'b0;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || bf_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL size_bad_reject: err=%0b busy=%0b bf_valid=%0b, required 1 0 0", err, busy, bf_valid);
    end
    tick;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL size_err_sticky: err=%0b, required 1", err);
    end
    fft_size = 6'b000001;
    start    = 1'b1;
    tick;
    start = 1'b0;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL size_one_reject: err=%0b busy=%0b, required 1 0", err, busy);
    end
    run_xfer("size_valid_clears", 6'b000100, 2, -1, 0, 1'b0);
`else
    run_xfer("size_0x14", 6'b010100, 4, -1, 0, 1'b0);
    run_xfer("size_0x00", 6'b000000, 1, -1, 0, 1'b0);
    run_xfer("size_0x01", 6'b000001, 1, -1, 0, 1'b0);
`endif
  endtask

  task automatic test_back_to_back;
    run_xfer("b2b_n2", 6'b000010, 1, -1, 0, 1'b0);
    run_xfer("b2b_n16_stall", 6'b010000, 4, 9, 2, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    bf_ready = 1'b0;
    fft_size = 6'd0;
    test_reset;
    test_n4_gap;
    test_n32;
    test_stall;
    test_reset_mid;
    test_size;
    test_start_ignored;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
